// File: rtl/input_port_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : input_port_buffer_if
// Description : Flit ingress, route-compute and crossbar handshake bundle for
//               one router input port. The slave modport belongs to the
//               buffer. The master modport belongs to its environment.
//               The pkt_cnt signal exists only when IPB_PKT_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface input_port_buffer_if #(
  parameter int FLIT_W = 8
);
  logic [FLIT_W-1:0] flit_in;
  logic              flit_in_valid;
  logic              flit_in_ready;
  logic [FLIT_W-1:0] head_flit;
  logic [4:0]        route_req_in;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_out_valid;
  logic [4:0]        out_req;
  logic              grant_in;
  logic              err_flag;
`ifdef IPB_PKT_CNT_EN
  logic [15:0]       pkt_cnt;
`endif

  modport slave (
`ifdef IPB_PKT_CNT_EN
    output pkt_cnt,
`endif
    input  flit_in, flit_in_valid, route_req_in, grant_in,
    output flit_in_ready, head_flit, flit_out, flit_out_valid, out_req, err_flag
  );

  modport master (
`ifdef IPB_PKT_CNT_EN
    input  pkt_cnt,
`endif
    output flit_in, flit_in_valid, route_req_in, grant_in,
    input  flit_in_ready, head_flit, flit_out, flit_out_valid, out_req, err_flag
  );
endinterface
`default_nettype wire

// File: rtl/input_port_buffer.sv
`default_nettype none
// ============================================================================
// Module      : input_port_buffer
// Description : Per-input-port flit FIFO with wormhole route-lock controller.
//               Buffers flits and presents the head flit to route compute.
//               Latches the one-hot output request from header to tail.
//               Forwards flits to the crossbar under a valid/grant handshake.
//               Optional packet counter: define IPB_PKT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module input_port_buffer #(
  parameter int FLIT_W  = 8,
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input_port_buffer_if.slave  bus
);

  localparam logic [1:0]       c_TYPE_HEADER = 2'b10;
  localparam logic [1:0]       c_TYPE_TAIL   = 2'b01;
  localparam logic [1:0]       c_TYPE_SINGLE = 2'b11;
  localparam logic [DEPTH_W:0] c_FULL_COUNT  = (DEPTH_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  logic [FLIT_W-1:0]  r_mem [DEPTH];
  logic [DEPTH_W-1:0] r_wr_ptr;
  logic [DEPTH_W-1:0] r_rd_ptr;
  logic [DEPTH_W:0]   r_count;
  state_t             r_state;
  logic               r_first;
  logic [4:0]         r_out_req;
  logic               r_err;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [FLIT_W-1:0]  w_head;
  logic [1:0]         w_head_type;
  logic               w_head_is_hdr;
  logic               w_head_is_tail;
  logic               w_req_onehot;
  logic               w_out_valid;

  assign w_full         = (r_count == c_FULL_COUNT);
  assign w_empty        = (r_count == '0);
  assign w_push         = bus.flit_in_valid && !w_full;
  assign w_head         = r_mem[r_rd_ptr];
  assign w_head_type    = w_head[7:6];
  assign w_head_is_hdr  = (w_head_type == c_TYPE_HEADER) || (w_head_type == c_TYPE_SINGLE);
  assign w_head_is_tail = (w_head_type == c_TYPE_TAIL)   || (w_head_type == c_TYPE_SINGLE);
  assign w_req_onehot   = (bus.route_req_in != 5'd0) &&
                          ((bus.route_req_in & (bus.route_req_in - 5'd1)) == 5'd0);
  assign w_out_valid    = (r_state == S_ACTIVE) && !w_empty;

  // Pop source depends on state: discard stray flits, forward granted flits, or drain.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:   w_pop = !w_empty && !w_head_is_hdr;
      S_ACTIVE: w_pop = w_out_valid && bus.grant_in;
      S_DROP:   w_pop = !w_empty;
      default:  w_pop = 1'b0;
    endcase
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.flit_in;
    end
  end

  // Circular pointers and occupancy; a simultaneous push and pop keeps count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Wormhole controller: lock the route on a header, hold it to the tail, drop bad packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_first   <= 1'b0;
      r_out_req <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (w_head_is_hdr) begin
              if (w_req_onehot) begin
                r_out_req <= bus.route_req_in;
                r_first   <= 1'b1;
                r_state   <= S_ACTIVE;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_DROP;
              end
            end else begin
              // Body or tail with no open packet is popped and discarded.
              r_err <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (w_pop) begin
            r_first <= 1'b0;
            // The packet's own header is the first pop; any later header is a protocol error.
            if (w_head_is_hdr && !r_first) r_err <= 1'b1;
            if (w_head_is_tail) begin
              r_out_req <= '0;
              r_state   <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (w_pop && w_head_is_tail) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IPB_PKT_CNT_EN
  logic [15:0] r_pkt_cnt;

  // Count packets whose tail is forwarded; dropped packets never reach ACTIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else if ((r_state == S_ACTIVE) && w_pop && w_head_is_tail) begin
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign bus.pkt_cnt = r_pkt_cnt;
`endif

  assign bus.flit_in_ready  = !w_full;
  assign bus.head_flit      = w_head;
  assign bus.flit_out       = w_head;
  assign bus.flit_out_valid = w_out_valid;
  assign bus.out_req        = r_out_req;
  assign bus.err_flag       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_input_port_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_port_buffer
// Description : Directed self-checking bench for input_port_buffer at node
//               x=2, y=1 with a route-compute model driving route_req_in.
//               Packet-counter checks apply when IPB_PKT_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_port_buffer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  input_port_buffer_if #(.FLIT_W(8)) bus ();

  input_port_buffer #(.FLIT_W(8), .DEPTH(4), .DEPTH_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // XY route compute for node x=2, y=1; own destination yields no request.
  function automatic logic [4:0] route_of(input logic [7:0] f);
    if (f[1:0] > 2'd2)      return 5'b00010;
    else if (f[1:0] < 2'd2) return 5'b00100;
    else if (f[3:2] > 2'd1) return 5'b10000;
    else if (f[3:2] < 2'd1) return 5'b01000;
    else                    return 5'b00000;
  endfunction

  assign bus.route_req_in = route_of(bus.head_flit);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef IPB_PKT_CNT_EN
  task automatic send_single(input logic [7:0] f);
    bus.flit_in       = f;
    bus.flit_in_valid = 1'b1;
    tick();
    bus.flit_in_valid = 1'b0;
    repeat (3) tick();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n             = 1'b0;
    bus.flit_in       = 8'h00;
    bus.flit_in_valid = 1'b0;
    bus.grant_in      = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_out_req",   16'(bus.out_req),        16'd0);
    chk("rst_out_valid", 16'(bus.flit_out_valid), 16'd0);
    chk("rst_err",       16'(bus.err_flag),       16'd0);
    chk("rst_ready",     16'(bus.flit_in_ready),  16'd1);
`ifdef IPB_PKT_CNT_EN
    chk("rst_pkt_cnt",   bus.pkt_cnt,             16'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Three-flit packet routed East, streamed with grant held high
    bus.grant_in      = 1'b1;
    bus.flit_in       = 8'h8F;
    bus.flit_in_valid = 1'b1;
    tick();
    bus.flit_in = 8'h05;
    tick();
    chk("t2_out_req",  16'(bus.out_req),        16'h02);
    chk("t2_valid0",   16'(bus.flit_out_valid), 16'd1);
    chk("t2_flit0",    16'(bus.flit_out),       16'h8F);
    bus.flit_in = 8'h46;
    tick();
    bus.flit_in_valid = 1'b0;
    chk("t2_valid1",   16'(bus.flit_out_valid), 16'd1);
    chk("t2_flit1",    16'(bus.flit_out),       16'h05);
    tick();
    chk("t2_flit2",    16'(bus.flit_out),       16'h46);
    chk("t2_req_hold", 16'(bus.out_req),        16'h02);
    tick();
    chk("t2_valid_end", 16'(bus.flit_out_valid), 16'd0);
    chk("t2_req_end",   16'(bus.out_req),        16'd0);

    // Fill to full with grant low, then a single granted pop
    bus.grant_in      = 1'b0;
    bus.flit_in_valid = 1'b1;
    bus.flit_in       = 8'h8F; tick();
    bus.flit_in       = 8'h05; tick();
    bus.flit_in       = 8'h05; tick();
    bus.flit_in       = 8'h46; tick();
    chk("t3_full_ready", 16'(bus.flit_in_ready), 16'd0);
    bus.flit_in = 8'h05;
    tick();
    chk("t3_still_full", 16'(bus.flit_in_ready), 16'd0);
    chk("t3_head",       16'(bus.flit_out),      16'h8F);
    bus.grant_in = 1'b1;
    tick();
    bus.grant_in      = 1'b0;
    bus.flit_in_valid = 1'b0;
    chk("t3_ready_back", 16'(bus.flit_in_ready), 16'd1);
    chk("t3_next_head",  16'(bus.flit_out),      16'h05);
    bus.grant_in = 1'b1;
    repeat (2) tick();
    chk("t3_tail_head",  16'(bus.flit_out),       16'h46);
    tick();
    chk("t3_drained",    16'(bus.flit_out_valid), 16'd0);
    chk("t3_no_err",     16'(bus.err_flag),       16'd0);

    // Header to own node without a route request: whole packet dropped
    bus.flit_in       = 8'h86;
    bus.flit_in_valid = 1'b1;
    tick();
    chk("t4_valid_a", 16'(bus.flit_out_valid), 16'd0);
    bus.flit_in = 8'h40;
    tick();
    bus.flit_in_valid = 1'b0;
    chk("t4_err",     16'(bus.err_flag),       16'd1);
    chk("t4_valid_b", 16'(bus.flit_out_valid), 16'd0);
    tick();
    chk("t4_valid_c", 16'(bus.flit_out_valid), 16'd0);
    tick();
    chk("t4_valid_d", 16'(bus.flit_out_valid), 16'd0);
    tick();
    chk("t4_valid_e", 16'(bus.flit_out_valid), 16'd0);
    chk("t4_out_req", 16'(bus.out_req),        16'd0);
    chk("t4_sticky",  16'(bus.err_flag),       16'd1);

    // Asynchronous reset in the middle of a stalled packet
    bus.grant_in      = 1'b0;
    bus.flit_in_valid = 1'b1;
    bus.flit_in       = 8'h8F; tick();
    bus.flit_in       = 8'h05; tick();
    bus.flit_in       = 8'h05; tick();
    bus.flit_in       = 8'h46; tick();
    bus.flit_in_valid = 1'b0;
    chk("t1_pre_req",   16'(bus.out_req),       16'h02);
    chk("t1_pre_ready", 16'(bus.flit_in_ready), 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_out_req",   16'(bus.out_req),        16'd0);
    chk("t1_out_valid", 16'(bus.flit_out_valid), 16'd0);
    chk("t1_err",       16'(bus.err_flag),       16'd0);
    chk("t1_ready",     16'(bus.flit_in_ready),  16'd1);
    tick();
    rst_n        = 1'b1;
    bus.grant_in = 1'b1;
    tick();
    chk("t1_empty", 16'(bus.flit_out_valid), 16'd0);

    // Stray body discarded, then a single-flit packet routed East
    bus.flit_in       = 8'h05;
    bus.flit_in_valid = 1'b1;
    tick();
    bus.flit_in = 8'hCF;
    tick();
    bus.flit_in_valid = 1'b0;
    chk("t5_err",      16'(bus.err_flag),       16'd1);
    chk("t5_idle",     16'(bus.flit_out_valid), 16'd0);
    tick();
    chk("t5_valid",    16'(bus.flit_out_valid), 16'd1);
    chk("t5_flit",     16'(bus.flit_out),       16'hCF);
    chk("t5_out_req",  16'(bus.out_req),        16'h02);
    tick();
    chk("t5_valid_end", 16'(bus.flit_out_valid), 16'd0);
    chk("t5_req_end",   16'(bus.out_req),        16'd0);

`ifdef IPB_PKT_CNT_EN
    // Packet counter: three forwarded, one dropped, then wrap from 0xFFFF
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_single(8'hCF);
    send_single(8'hCF);
    send_single(8'hC6);
    send_single(8'hCF);
    chk("t6_cnt3", bus.pkt_cnt, 16'd3);
    @(negedge clk);
    dut.r_pkt_cnt = 16'hFFFF;
    tick();
    send_single(8'hCF);
    chk("t6_wrap", bus.pkt_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
